// File: rtl/hc595_and_feeder_if.sv
// Host-side serial link and storage outputs of the 595-style feeder.
// Host drives ser/sh_en/lat_en/sr_clr/oe_n; the feeder drives q, q_en, qh_s,
// frame_rdy and ovr. q[WIDTH/2-1:0] feeds AND input A, the upper half feeds B.
interface hc595_and_feeder_if #(
  parameter int WIDTH = 8
);
  logic             ser;
  logic             sh_en;
  logic             lat_en;
  logic             sr_clr;
  logic             oe_n;
  logic [WIDTH-1:0] q;
  logic             q_en;
  logic             qh_s;
  logic             frame_rdy;
  logic             ovr;

  modport master (
    output ser, sh_en, lat_en, sr_clr, oe_n,
    input  q, q_en, qh_s, frame_rdy, ovr
  );

  modport slave (
    input  ser, sh_en, lat_en, sr_clr, oe_n,
    output q, q_en, qh_s, frame_rdy, ovr
  );
endinterface

// File: rtl/hc595_and_feeder.sv
// 74HC595-style shift register + storage latch feeding the quad AND stage,
// with a bit counter, frame-ready flag, sticky overrun flag and optional auto-latch.
// Ports: clk_i, rst_i (sync, active-high), bus (slave modport of hc595_and_feeder_if).
// WIDTH must be even and >= 2. Storage updates one edge after a latch is sampled.
module hc595_and_feeder #(
  parameter int WIDTH      = 8,
  parameter bit AUTO_LATCH = 1'b0
) (
  input logic               clk_i,
  input logic               rst_i,
  hc595_and_feeder_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  // Counter states: EMPTY (0), FILLING (between), FULL (WIDTH).
  localparam logic [CW-1:0] CNT_EMPTY = '0;
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(WIDTH);

  // Bit 0 here is sr[1] of the part: the newest serial bit enters at the bottom.
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] st_q, st_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovr_q, ovr_d;

  logic cnt_full;
  logic latch_eff;

  assign cnt_full  = (cnt_q == CNT_FULL);
  // Auto-latch fires on the edge after the WIDTH-th shift, while the frame sits full.
  assign latch_eff = bus.lat_en | (AUTO_LATCH & cnt_full);

  always_comb begin
    sr_d  = sr_q;
    st_d  = st_q;
    cnt_d = cnt_q;
    ovr_d = ovr_q;

    // Storage always captures the pre-edge shift register, so a shift and
    // latch on the same edge leaves storage one bit behind.
    if (latch_eff) begin
      st_d = sr_q;
    end

    if (bus.sr_clr) begin
      sr_d  = '0;
      cnt_d = CNT_EMPTY;
      ovr_d = 1'b0;
    end else begin
      if (bus.sh_en) begin
        sr_d = {sr_q[WIDTH-2:0], bus.ser};
      end

      if (latch_eff) begin
        // The bit shifted on the latch edge is the first bit of the next frame.
        cnt_d = bus.sh_en ? CNT_ONE : CNT_EMPTY;
      end else if (bus.sh_en) begin
        if (!cnt_full) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          // Saturate and flag: an unlatched bit has just been pushed out.
          ovr_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q  <= '0;
      st_q  <= '0;
      cnt_q <= CNT_EMPTY;
      ovr_q <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      st_q  <= st_d;
      cnt_q <= cnt_d;
      ovr_q <= ovr_d;
    end
  end

  assign bus.q         = st_q;
  assign bus.q_en      = ~bus.oe_n & ~rst_i;
  assign bus.qh_s      = sr_q[WIDTH-1];
  assign bus.frame_rdy = cnt_full;
  assign bus.ovr       = ovr_q;
endmodule

// File: doc/hc595_and_feeder.md
Name: hc595_and_feeder

Overview:
- Serial-in/parallel-out shift register with a storage latch, modelled on the 74HC595. It is the stage directly upstream of the quad 2-input AND block.
- Storage output Q[4:1] drives A[4:1] and Q[8:5] drives B[4:1] of the AND stage, so a host can load gate stimulus over a 3-wire serial link.
- Adds a bit counter, a frame-ready flag, an overrun flag and an optional auto-latch mode.

Parameters:
- WIDTH, 8, shift/storage register width; must be even and ≥ 2. Lower half feeds A, upper half feeds B.
- AUTO_LATCH, 0, when 1 the storage register loads automatically once a full frame is shifted.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  reset, synchronous, active-high.
- SER  input  1  serial data in.
- SH_EN  input  1  shift enable (SRCLK qualifier).
- LAT_EN  input  1  storage latch enable (RCLK qualifier).
- SR_CLR  input  1  synchronous clear of shift register and counter, active-high.
- OE_N  input  1  output enable, active-low.
- Q  output  WIDTH  storage register contents; Q[WIDTH/2:1] to A, Q[WIDTH:WIDTH/2+1] to B.
- Q_EN  output  1  pad enable for Q = !OE_N & !RST (combinational).
- QH_S  output  1  serial cascade out = sr[WIDTH].
- FRAME_RDY  output  1  high while CNT == WIDTH.
- OVR  output  1  sticky overrun flag.

Behaviour:
- Internal state: sr[WIDTH:1] (shift register), st[WIDTH:1] (storage register, drives Q), CNT (0..WIDTH, $clog2(WIDTH+1) bits), OVR.
- Reset (RST=1 at edge): sr=0, st=0, CNT=0, OVR=0. Outputs are therefore Q=0, QH_S=0, FRAME_RDY=0, OVR=0, and Q_EN=0 while RST is high. RST overrides all other inputs.
- Shift (SH_EN=1): sr[1]<=SER, sr[i]<=sr[i-1]. The first bit shifted reaches sr[WIDTH] after WIDTH shifts. QH_S is sr[WIDTH], updated the same edge.
- Latch (LAT_EN=1): st<=sr using the pre-edge value of sr. If shift and latch occur on the same edge, st receives the old sr, i.e. storage lags the shift register by one clock. This matches a 595 with SRCLK tied to RCLK.
- Auto latch (AUTO_LATCH=1): an internal latch is asserted on any edge where CNT==WIDTH. It is OR-ed with LAT_EN, so storage loads one cycle after the WIDTH-th shift. When AUTO_LATCH=0 only LAT_EN latches.
- Counter states:
  - EMPTY: CNT=0.
  - FILLING: 0<CNT<WIDTH.
  - FULL: CNT=WIDTH.
- Counter transitions on each edge, in priority order:
  - SR_CLR: CNT<=0.
  - Effective latch with shift: CNT<=1.
  - Effective latch without shift: CNT<=0.
  - Shift with CNT<WIDTH: CNT<=CNT+1.
  - Shift with CNT==WIDTH: CNT holds at WIDTH (saturates, no wrap).
- OVR: set on a shift while CNT==WIDTH with no effective latch that edge. Cleared only by RST or SR_CLR.
- SR_CLR: clears sr, CNT and OVR. It has priority over a simultaneous shift (sr=0 after the edge). It does not touch st. A simultaneous LAT_EN still latches the pre-edge sr.
- OE_N affects only Q_EN. st keeps updating while outputs are disabled.
- No latency beyond one register stage: Q changes on the edge after LAT_EN is sampled.
- Reset mid-frame: a partial frame is discarded and the next frame starts at CNT=0.

Test Plan:
- Frame load: after reset, shift 0xA5 MSB-first (8 cycles, SH_EN=1), then LAT_EN for 1 cycle. Required: Q=0xA5, downstream A=0x5, B=0xA, Y=0x0. FRAME_RDY is 1 after the 8th shift and 0 after the latch.
- AND stimulus plus auto latch: with AUTO_LATCH=1, shift 0xFF. Required: Q=0xFF one cycle after the 8th shift with no LAT_EN, Y=0xF, CNT back to 0.
- Simultaneous shift and latch: with sr=0x3C, assert SH_EN=1, SER=1, LAT_EN=1 on the same edge. Required: Q=0x3C, sr=0x79, CNT=1.
- Overrun: shift 9 bits with no latch. Required: OVR=1, CNT holds at 8, QH_S shows the 2nd bit shifted. Then SR_CLR gives OVR=0, CNT=0, sr=0, Q unchanged.
- Output enable and reset: with Q=0xA5, OE_N=1 gives Q_EN=0 and Q still 0xA5. Assert RST mid-frame after 4 shifts. Required: Q=0, QH_S=0, CNT=0, OVR=0 next edge; Q_EN=0 while RST=1.
